// File: rtl/comm_master.sv
// rtl/comm_master.sv - host-side UART command master: 16-bit command out as two 8N1 frames, response bytes in
// Optional build macro COMM_MASTER_CMPLT_ON_RESP_EN: cmd_cmplt waits for the first response byte after transmission.
module comm_master #(
  parameter int BAUD_DIV = 108
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic        TX,
  input  logic        RX,
  output logic        rdy,
  output logic [7:0]  rx_data,
  input  logic        clr_rdy
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {C_IDLE, C_SEND_HI, C_SEND_LO} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  cmd_state_t       cmd_state;
  logic [7:0]       lo_byte;
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bits;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [7:0]       rx_shift;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bits;
  logic             rx_byte_done;

`ifdef COMM_MASTER_CMPLT_ON_RESP_EN
  logic             resp_armed;
`endif

  assign rx_byte_done = (rx_state == R_STOP) && (rx_cnt == BIT_END);

  // TX follows tx_shift[0] one cycle late, so every bit keeps its full BAUD_DIV width on the pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_state <= C_IDLE;
      lo_byte   <= 8'h00;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bits   <= 4'd0;
      TX        <= 1'b1;
      cmd_cmplt <= 1'b0;
`ifdef COMM_MASTER_CMPLT_ON_RESP_EN
      resp_armed <= 1'b0;
`endif
    end else begin
      TX <= (cmd_state == C_IDLE) ? 1'b1 : tx_shift[0];
      case (cmd_state)
        C_IDLE: begin
          if (snd_cmd) begin
            lo_byte   <= cmd[7:0];
            tx_shift  <= {1'b1, cmd[15:8], 1'b0};
            tx_cnt    <= '0;
            tx_bits   <= 4'd0;
            cmd_cmplt <= 1'b0;
            cmd_state <= C_SEND_HI;
`ifdef COMM_MASTER_CMPLT_ON_RESP_EN
            resp_armed <= 1'b0;
          end else if (resp_armed && rx_byte_done) begin
            cmd_cmplt  <= 1'b1;
            resp_armed <= 1'b0;
`endif
          end
        end
        default: begin
          if (tx_cnt != BIT_END) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            if (tx_bits != 4'd9) begin
              tx_bits  <= tx_bits + 1'b1;
              tx_shift <= {1'b1, tx_shift[9:1]};
            end else begin
              tx_bits <= 4'd0;
              if (cmd_state == C_SEND_HI) begin
                tx_shift  <= {1'b1, lo_byte, 1'b0};
                cmd_state <= C_SEND_LO;
              end else begin
                cmd_state <= C_IDLE;
`ifdef COMM_MASTER_CMPLT_ON_RESP_EN
                resp_armed <= 1'b1;
`else
                cmd_cmplt  <= 1'b1;
`endif
              end
            end
          end
        end
      endcase
    end
  end

  // Stop bit is sampled at mid-bit so the next start edge of a back-to-back stream is never missed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= R_IDLE;
      rx_shift <= 8'h00;
      rx_cnt   <= '0;
      rx_bits  <= 4'd0;
      rdy      <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      if (rx_byte_done)
        rdy <= 1'b1;
      else if (clr_rdy)
        rdy <= 1'b0;

      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bits  <= 4'd0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 4'd7)
              rx_state <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_data  <= rx_shift;
            rx_state <= R_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// tb/tb_comm_master.sv - directed self-checking bench for comm_master
module tb_comm_master;

  localparam int BD        = 16;
  localparam int DONE_EDGE = 3 + BD / 2 + 9 * BD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        RX;
  logic        clr_rdy;
  logic        cmd_cmplt;
  logic        TX;
  logic        rdy;
  logic [7:0]  rx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .cmd_cmplt (cmd_cmplt),
    .TX        (TX),
    .RX        (RX),
    .rdy       (rdy),
    .rx_data   (rx_data),
    .clr_rdy   (clr_rdy)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_frame(input logic [7:0] b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = 1'b1;
    tick(BD);
  endtask

  // Waits for a start bit, then samples each bit at its middle; fr[0] is the start bit.
  task automatic tx_frame(output logic [9:0] fr, output int t_start);
    int t;
    t = 0;
    fr = '0;
    while (TX !== 1'b0 && t < 4 * BD) begin
      tick();
      t++;
    end
    t_start = cyc;
    tick(BD / 2);
    fr[0] = TX;
    for (int i = 1; i < 10; i++) begin
      tick(BD);
      fr[i] = TX;
    end
  endtask

  task automatic pulse_snd(input logic [15:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
  endtask

  logic [9:0]  fr;
  int          t_snd, t_hi, t_lo, t;
  logic [15:0] resp_cmd [4];
  logic [7:0]  resp_val [4];

  initial begin
    resp_cmd = '{16'h4BAF, 16'h6BAF, 16'h0B00, 16'h2C00};
    resp_val = '{8'hA5, 8'hEE, 8'hAF, 8'hEE};
    rst_n = 1'b0; cmd = 16'h0000; snd_cmd = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("reset_tx", TX, 1);
    check("reset_cmplt", cmd_cmplt, 0);
    check("reset_rdy", rdy, 0);
    check("reset_rx_data", rx_data, 8'h00);

    // Command 0x4BAF, with a second snd_cmd injected during SEND_HI
    t_snd = cyc;
    pulse_snd(16'h4BAF);
    tx_frame(fr, t_hi);
    check("hi_start_latency", t_hi - t_snd, 2);
    check("hi_frame", fr, {1'b1, 8'h4B, 1'b0});
    pulse_snd(16'h1234);
    tx_frame(fr, t_lo);
    check("lo_frame", fr, {1'b1, 8'hAF, 1'b0});
    check("lo_no_gap", t_lo - t_hi, 10 * BD);
    check("cmplt_before_stop_end", cmd_cmplt, 0);
    t = 0;
    while (cmd_cmplt !== 1'b1 && t < 4 * BD) begin
      tick();
      t++;
    end
    check("cmplt_latency_in_window", ((cyc - t_snd) >= 20 * BD) && ((cyc - t_snd) <= 20 * BD + 2), 1);
    tick(BD);
    check("idle_after_cmd", TX, 1);

    // Command/response exchanges
    for (int k = 0; k < 4; k++) begin
      pulse_snd(resp_cmd[k]);
      check("cmplt_cleared", cmd_cmplt, 0);
      tick(21 * BD);
      rx_frame(resp_val[k]);
      check("resp_rdy", rdy, 1);
      check("resp_data", rx_data, resp_val[k]);
      check("resp_cmplt", cmd_cmplt, 1);
      clr_rdy = 1'b1;
      tick();
      clr_rdy = 1'b0;
      check("resp_clr", rdy, 0);
    end

    // Overrun with clr_rdy on the completion edge: set wins, data replaced
    rx_frame(8'h11);
    check("ovr_first_rdy", rdy, 1);
    check("ovr_first_data", rx_data, 8'h11);
    fork
      rx_frame(8'h22);
      begin
        tick(DONE_EDGE - 1);
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
      end
    join
    check("set_wins_rdy", rdy, 1);
    check("overrun_data", rx_data, 8'h22);
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
    check("ovr_clr", rdy, 0);

    // 384 back-to-back frames
    fork
      begin
        for (int k = 0; k < 384; k++)
          rx_frame(8'((k % 128) + 1));
      end
      begin
        for (int k = 0; k < 384; k++) begin
          int w;
          w = 0;
          while (rdy !== 1'b1 && w < 12 * BD) begin
            tick();
            w++;
          end
          check("stream_rdy", rdy, 1);
          check("stream_data", rx_data, (k % 128) + 1);
          if (rdy !== 1'b1) break;
          clr_rdy = 1'b1;
          tick();
          clr_rdy = 1'b0;
          check("stream_clr", rdy, 0);
        end
      end
    join
    tick(2 * BD);

    // Short low glitch is a false start
    RX = 1'b0;
    tick(BD / 2 - 2);
    RX = 1'b1;
    tick(12 * BD);
    check("glitch_no_rdy", rdy, 0);
    check("glitch_data_kept", rx_data, 8'h80);
    rx_frame(8'h3C);
    check("post_glitch_rdy", rdy, 1);
    check("post_glitch_data", rx_data, 8'h3C);

    // Reset during transmission
    pulse_snd(16'h0000);
    tick(3 * BD);
    check("mid_tx_low", TX, 0);
    rst_n = 1'b0;
    tick();
    check("rst_tx_high", TX, 1);
    check("rst_cmplt", cmd_cmplt, 0);
    check("rst_rdy", rdy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    tick(2);
    t_snd = cyc;
    pulse_snd(16'h4BAF);
    tx_frame(fr, t_hi);
    check("after_rst_start", t_hi - t_snd, 2);
    check("after_rst_hi_frame", fr, {1'b1, 8'h4B, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
